register_bank: RTL

//  Parametrised multi-register bank for the bus-based CPU datapath: NUM_REGS registers of

---
 rtl/register_bank_pkg.sv | 21 ++
 rtl/register_bank_if.sv | 30 +++
 rtl/regbank_scoreboard.sv | 39 +++
 rtl/register_bank.sv | 112 +++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// rtl/register_bank_pkg.sv - shared CPU register-file constants, read-source enum, address legality helper
package register_bank_pkg;

  localparam int          CPU_DATA_WIDTH = 32;
  localparam int          CPU_NUM_REGS   = 16;
  localparam int unsigned CPU_R0_INDEX   = 0;

  typedef enum logic [1:0] {
    RD_ZERO = 2'd0,
    RD_FWD  = 2'd1,
    RD_REG  = 2'd2
  } rd_src_e;

  // An address is usable when it maps to a real register that is not the hardwired zero.
  function automatic logic addr_legal(input int unsigned addr,
                                      input int unsigned num_regs,
                                      input logic        r0_zero);
    return (addr < num_regs) && !(r0_zero && (addr == CPU_R0_INDEX));
  endfunction

endpackage

// File: rtl/register_bank_if.sv
// rtl/register_bank_if.sv - write/reserve/read bus between control unit, BusMuxOut and the register bank
interface register_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
);
  logic                  soft_clr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  res_en;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic [ADDR_WIDTH-1:0] rd_a_addr;
  logic [DATA_WIDTH-1:0] rd_a_data;
  logic                  rd_a_busy;
  logic [ADDR_WIDTH-1:0] rd_b_addr;
  logic [DATA_WIDTH-1:0] rd_b_data;
  logic                  rd_b_busy;
  logic [NUM_REGS-1:0]   busy_vec;

  modport master (
    output soft_clr, wr_en, wr_addr, wr_data, res_en, res_addr, rd_a_addr, rd_b_addr,
    input  rd_a_data, rd_a_busy, rd_b_data, rd_b_busy, busy_vec
  );

  modport slave (
    input  soft_clr, wr_en, wr_addr, wr_data, res_en, res_addr, rd_a_addr, rd_b_addr,
    output rd_a_data, rd_a_busy, rd_b_data, rd_b_busy, busy_vec
  );
endinterface

// File: rtl/regbank_scoreboard.sv
// rtl/regbank_scoreboard.sv - per-register busy bits for multi-cycle producers
module regbank_scoreboard #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  soft_clr_i,
  input  logic                  set_en_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  output logic [NUM_REGS-1:0]   busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied after clear so a reserve issued alongside the completing write keeps the reg busy.
  always_comb begin
    busy_d = busy_q;
    if (soft_clr_i) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (clr_en_i && (clr_addr_i == ADDR_WIDTH'(i))) busy_d[i] = 1'b0;
        if (set_en_i && (set_addr_i == ADDR_WIDTH'(i))) busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/register_bank.sv
// rtl/register_bank.sv - general-purpose register bank, two forwarded read ports, busy scoreboard
module register_bank
  import register_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int                    NUM_REGS   = CPU_NUM_REGS,
  parameter int                    ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter bit                    R0_ZERO    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
  input  logic            clock,
  input  logic            clear,
  register_bank_if.slave  bus_if
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic                  wr_legal;
  logic                  res_legal;
  logic                  wr_fire;
  logic                  res_fire;

  assign wr_legal  = addr_legal(32'(bus_if.wr_addr), NUM_REGS, R0_ZERO);
  assign res_legal = addr_legal(32'(bus_if.res_addr), NUM_REGS, R0_ZERO);
  // Gating with clear keeps a write that is pending during reset from leaking onto the read ports.
  assign wr_fire   = clear && bus_if.wr_en && wr_legal && !bus_if.soft_clr;
  assign res_fire  = clear && bus_if.res_en && res_legal && !bus_if.soft_clr;

  always_comb begin
    regs_d = regs_q;
    if (bus_if.soft_clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs_d[i] = INIT;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus_if.wr_addr == ADDR_WIDTH'(i)) regs_d[i] = bus_if.wr_data;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= INIT;
    end else begin
      regs_q <= regs_d;
    end
  end

  regbank_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk_i      (clock),
    .rst_ni     (clear),
    .soft_clr_i (bus_if.soft_clr),
    .set_en_i   (res_fire),
    .set_addr_i (bus_if.res_addr),
    .clr_en_i   (wr_fire),
    .clr_addr_i (bus_if.wr_addr),
    .busy_o     (busy_q)
  );

  assign bus_if.busy_vec = busy_q;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] stored;
    logic                  stored_busy;
    rd_src_e               src;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;

    assign addr = (p == 0) ? bus_if.rd_a_addr : bus_if.rd_b_addr;

    always_comb begin
      stored      = '0;
      stored_busy = 1'b0;
      src         = RD_ZERO;
      data        = '0;
      busy        = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == ADDR_WIDTH'(i)) begin
          stored      = regs_q[i];
          stored_busy = busy_q[i];
        end
      end
      if (addr_legal(32'(addr), NUM_REGS, R0_ZERO)) begin
        src = (wr_fire && (bus_if.wr_addr == addr)) ? RD_FWD : RD_REG;
      end
      case (src)
        RD_FWD: begin
          data = bus_if.wr_data;
          busy = 1'b0;
        end
        RD_REG: begin
          data = stored;
          busy = stored_busy;
        end
        default: begin
          data = '0;
          busy = 1'b0;
        end
      endcase
    end
  end

  assign bus_if.rd_a_data = g_rd[0].data;
  assign bus_if.rd_a_busy = g_rd[0].busy;
  assign bus_if.rd_b_data = g_rd[1].data;
  assign bus_if.rd_b_busy = g_rd[1].busy;

endmodule
